// File: rtl/mfp_seven_segment_scan_controller_pkg.sv
// Shared configuration for the seven-segment scan controller.
// Holds the default geometry (N_DIGITS, SCAN_DIV), the FSM state encoding
// and the blank segment pattern, so the top and the bench agree on them.
// No ports.
package mfp_seven_segment_scan_controller_pkg;

  localparam int DEF_N_DIGITS = 8;
  localparam int DEF_SCAN_DIV = 50000;

  // All state encodings live here so a waveform viewer and any future
  // block reading the state agree on the numbering.
  typedef enum logic [1:0] {
    ST_DISABLED = 2'd0,
    ST_GUARD    = 2'd1,
    ST_DRIVE    = 2'd2,
    ST_DARK     = 2'd3
  } scan_state_t;

  // Active-low segments: all ones is every segment dark.
  localparam logic [6:0] SEG_OFF = 7'h7F;

endpackage

// File: rtl/mfp_single_digit_seven_segment_display.sv
// Hex nibble to seven-segment decoder, active-low outputs.
// Ports:
//   i_nibble  in  4  value 0..F
//   o_seg     out 7  {g,f,e,d,c,b,a}, 0 = segment lit
module mfp_single_digit_seven_segment_display (
  input  logic [3:0] i_nibble,
  output logic [6:0] o_seg
);

  always_comb begin
    o_seg = 7'h7F;
    case (i_nibble)
      4'h0: o_seg = 7'h40;
      4'h1: o_seg = 7'h79;
      4'h2: o_seg = 7'h24;
      4'h3: o_seg = 7'h30;
      4'h4: o_seg = 7'h19;
      4'h5: o_seg = 7'h12;
      4'h6: o_seg = 7'h02;
      4'h7: o_seg = 7'h78;
      4'h8: o_seg = 7'h00;
      4'h9: o_seg = 7'h10;
      4'hA: o_seg = 7'h08;
      4'hB: o_seg = 7'h03;
      4'hC: o_seg = 7'h46;
      4'hD: o_seg = 7'h21;
      4'hE: o_seg = 7'h06;
      4'hF: o_seg = 7'h0E;
      default: o_seg = 7'h7F;
    endcase
  end

endmodule

// File: rtl/mfp_seven_segment_scan_controller.sv
// Multiplexed seven-segment scan controller with per-digit blanking,
// decimal points and 8-level PWM brightness.
// Each digit slot is SCAN_DIV cycles split into 8 sub-phases; sub-phase 0
// is a dead-time guard, sub-phases 1..brightness drive the digit.
// Ports:
//   i_clk         in  1            clock, rising edge
//   i_rst         in  1            asynchronous active-high reset
//   i_enable      in  1            scanning on when 1
//   i_hex_value   in  4*N_DIGITS   nibble i shown on digit i
//   i_digit_en    in  N_DIGITS     0 blanks that digit
//   i_dot         in  N_DIGITS     decimal point request per digit
//   i_brightness  in  3            duty level, 0 dark .. 7 = 7/8
//   o_anode       out N_DIGITS     active-low digit select
//   o_seg         out 7            active-low segments {g..a}
//   o_dp          out 1            active-low decimal point
//   o_frame_done  out 1            one-cycle pulse after the last slot
module mfp_seven_segment_scan_controller
  import mfp_seven_segment_scan_controller_pkg::*;
#(
  parameter int N_DIGITS = DEF_N_DIGITS,
  parameter int SCAN_DIV = DEF_SCAN_DIV
) (
  input  logic                    i_clk,
  input  logic                    i_rst,
  input  logic                    i_enable,
  input  logic [4*N_DIGITS-1:0]   i_hex_value,
  input  logic [N_DIGITS-1:0]     i_digit_en,
  input  logic [N_DIGITS-1:0]     i_dot,
  input  logic [2:0]              i_brightness,
  output logic [N_DIGITS-1:0]     o_anode,
  output logic [6:0]              o_seg,
  output logic                    o_dp,
  output logic                    o_frame_done
);

  localparam int PRE_W = $clog2(SCAN_DIV / 8);
  localparam int IDX_W = $clog2(N_DIGITS);
  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(SCAN_DIV / 8 - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(N_DIGITS - 1);

  scan_state_t           r_state;
  logic [PRE_W-1:0]      r_pre;
  logic [2:0]            r_sub;
  logic [IDX_W-1:0]      r_idx;

  logic [4*N_DIGITS-1:0] r_sh_hex;
  logic [N_DIGITS-1:0]   r_sh_en;
  logic [N_DIGITS-1:0]   r_sh_dot;
  logic [2:0]            r_sh_bright;

  logic [N_DIGITS-1:0]   r_anode;
  logic [6:0]            r_seg;
  logic                  r_dp;
  logic                  r_frame_done;

  logic                  w_pre_wrap;
  logic                  w_sub_wrap;
  logic                  w_idx_wrap;
  logic                  w_capture;
  logic [N_DIGITS-1:0]   w_sel;
  logic [3:0]            w_nibble;
  logic [6:0]            w_dec_seg;

  assign w_pre_wrap = (r_pre == PRE_LAST);
  assign w_sub_wrap = w_pre_wrap && (r_sub == 3'd7);
  assign w_idx_wrap = w_sub_wrap && (r_idx == IDX_LAST);

  // Shadows load on the edge that starts a frame: leaving DISABLED, or the
  // last cycle of the last slot while still enabled.
  assign w_capture = i_enable && ((r_state == ST_DISABLED) || w_idx_wrap);

  assign w_sel    = N_DIGITS'(1) << r_idx;
  assign w_nibble = r_sh_hex[r_idx*4 +: 4];

  mfp_single_digit_seven_segment_display u_dec (
    .i_nibble (w_nibble),
    .o_seg    (w_dec_seg)
  );

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state      <= ST_DISABLED;
      r_pre        <= '0;
      r_sub        <= '0;
      r_idx        <= '0;
      r_sh_hex     <= '0;
      r_sh_en      <= '0;
      r_sh_dot     <= '0;
      r_sh_bright  <= '0;
      r_anode      <= '1;
      r_seg        <= SEG_OFF;
      r_dp         <= 1'b1;
      r_frame_done <= 1'b0;
    end else begin
      // Output stage: decoded from this cycle's state, visible next cycle.
      // Segments track the current digit even in GUARD, so digit-to-digit
      // segment changes always land while every anode is off.
      r_anode      <= (r_state == ST_DRIVE && r_sh_en[r_idx]) ? ~w_sel : '1;
      r_seg        <= (r_state == ST_DISABLED) ? SEG_OFF : w_dec_seg;
      r_dp         <= !(r_state == ST_DRIVE && r_sh_dot[r_idx]);
      r_frame_done <= (r_state != ST_DISABLED) && i_enable && w_idx_wrap;

      if (w_capture) begin
        r_sh_hex    <= i_hex_value;
        r_sh_en     <= i_digit_en;
        r_sh_dot    <= i_dot;
        r_sh_bright <= i_brightness;
      end

      if (!i_enable) begin
        r_state <= ST_DISABLED;
        r_pre   <= '0;
        r_sub   <= '0;
        r_idx   <= '0;
      end else if (r_state == ST_DISABLED) begin
        r_state <= ST_GUARD;
      end else begin
        r_pre <= w_pre_wrap ? '0 : r_pre + 1'b1;
        if (w_pre_wrap) begin
          r_sub <= r_sub + 3'd1;
          if (r_sub == 3'd7) begin
            r_idx   <= (r_idx == IDX_LAST) ? '0 : r_idx + 1'b1;
            r_state <= ST_GUARD;
          end else if (r_sub == 3'd0) begin
            r_state <= (r_sh_bright != 3'd0) ? ST_DRIVE : ST_DARK;
          end else if (r_state == ST_DRIVE && r_sub >= r_sh_bright) begin
            // next sub-phase exceeds the duty level
            r_state <= ST_DARK;
          end
        end
      end
    end
  end

  assign o_anode      = r_anode;
  assign o_seg        = r_seg;
  assign o_dp         = r_dp;
  assign o_frame_done = r_frame_done;

endmodule
